// File: rtl/stream_pkg.sv
// Shared types and constants for the stream generator and its throttle LFSR.
package stream_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} gen_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;
endpackage

// File: rtl/stream_gen_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), right-shifting, reloaded with seed on rst.
module lfsr16
  import stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= seed;
    else     q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end
endmodule

// File: rtl/stream_gen.sv
// Valid/ready traffic generator: num_txn beats of incrementing data from base.
// Define STREAM_GEN_THROTTLE_EN to gate valid rises with an LFSR.
module stream_gen
  import stream_pkg::*;
#(
  parameter int          DW    = 16,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic [DW-1:0]    base,
  input  logic             up_ready,
  output logic             up_valid,
  output logic [DW-1:0]    up_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] txn_cnt
);
  if (SEED == 16'h0000) begin : g_seed_chk
    $error("stream_gen: SEED must be non-zero");
  end

  gen_state_t       state, state_nx;
  logic [CNT_W-1:0] len, len_nx, cnt_nx;
  logic [DW-1:0]    data_nx;
  logic             valid_nx, busy_nx, done_nx;
  logic             go, xfer, last;

  // go gates the rising edge of up_valid; once high, valid waits for the transfer
`ifdef STREAM_GEN_THROTTLE_EN
  logic [15:0] lfsr_q;
  lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .q(lfsr_q));
  assign go = lfsr_q[0];
`else
  assign go = 1'b1;
`endif

  assign xfer = up_valid && up_ready;
  assign last = xfer && (txn_cnt == len - CNT_W'(1));

  always_comb begin
    state_nx = state;
    len_nx   = len;
    cnt_nx   = txn_cnt;
    data_nx  = up_data;
    valid_nx = up_valid;
    busy_nx  = busy;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_nx = '0;
          if (num_txn != '0) begin
            len_nx   = num_txn;
            data_nx  = base;
            busy_nx  = 1'b1;
            valid_nx = go;
            state_nx = S_RUN;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (txn_cnt < len) cnt_nx = txn_cnt + CNT_W'(1);
          data_nx = up_data + DW'(1);
          if (last) begin
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            state_nx = S_DONE;
          end else begin
            valid_nx = go;
          end
        end else if (!up_valid) begin
          valid_nx = go;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= '0;
      txn_cnt  <= '0;
      up_data  <= '0;
      up_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      len      <= len_nx;
      txn_cnt  <= cnt_nx;
      up_data  <= data_nx;
      up_valid <= valid_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end
endmodule

// File: tb/tb_stream_gen.sv
// Self-checking bench for stream_gen: scoreboard expects beat k of a run to carry base+k.
module tb_stream_gen;
  localparam int DW    = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_txn = '0;
  logic [DW-1:0]    base = '0;
  logic             up_ready = 1'b0;
  logic             up_valid, busy, done;
  logic [DW-1:0]    up_data;
  logic [CNT_W-1:0] txn_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_gen #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_txn(num_txn), .base(base),
    .up_ready(up_ready), .up_valid(up_valid), .up_data(up_data),
    .busy(busy), .done(done), .txn_cnt(txn_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, up_valid, 0);
    chk({tag, "_data"},  up_data,  0);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_cnt"},   txn_cnt,  0);
  endtask

  // One command. rmask[i-1] is up_ready on run cycle i (high after cycle 32).
  // poke_at: run cycle on which a stray start is driven. rst_after: reset once that many beats moved.
  task automatic run_txn(input int num, input logic [DW-1:0] b, input logic [31:0] rmask,
                         input int poke_at, input int rst_after);
    int k, cyc, gaps;
    logic pend;
    logic [DW-1:0] pdata, e;
    k = 0; cyc = 0; gaps = 0; pend = 1'b0; pdata = '0;
    start = 1'b1; num_txn = CNT_W'(num); base = b; up_ready = 1'b0;
    step();
    start = 1'b0;
    if (num == 0) begin
      chk("zero_done",  done,     1);
      chk("zero_valid", up_valid, 0);
      chk("zero_busy",  busy,     0);
      chk("zero_cnt",   txn_cnt,  0);
      step();
      chk("zero_done_clr", done,     0);
      chk("zero_valid2",   up_valid, 0);
      return;
    end
    while (k < num && cyc < 4000) begin
      cyc++;
      chk("run_busy", busy, 1);
      chk("run_cnt", txn_cnt, k);
      if (pend) begin
        chk("hold_valid", up_valid, 1);
        chk("hold_data",  up_data,  pdata);
      end
`ifdef STREAM_GEN_THROTTLE_EN
      if (!up_valid) gaps++;
`else
      chk("cont_valid", up_valid, 1);
`endif
      start    = (cyc == poke_at);
      num_txn  = 16'd7;
      base     = 16'h5555;
      up_ready = (cyc <= 32) ? rmask[cyc-1] : 1'b1;
      if (up_valid && up_ready) begin
        e = b + DW'(k);
        chk("beat_data", up_data, e);
        k++;
      end
      pend  = up_valid && !up_ready;
      pdata = up_data;
      if (rst_after > 0 && k == rst_after) begin
        rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk_reset_vals("midrst");
        return;
      end
      step();
    end
    start = 1'b0;
    chk("beats", k, num);
`ifndef STREAM_GEN_THROTTLE_EN
    if (rmask == 32'hFFFF_FFFF) chk("latency", cyc, num);
`else
    if (num >= 50) chk("gaps_seen", gaps > 0, 1);
`endif
    up_ready = 1'($urandom);
    chk("end_valid", up_valid, 0);
    chk("end_done",  done,     1);
    chk("end_busy",  busy,     0);
    chk("end_cnt",   txn_cnt,  num);
    start = 1'b1;   // arrives during DONE: must be dropped
    step();
    start = 1'b0;
    chk("idle_done",  done,     0);
    chk("idle_valid", up_valid, 0);
    chk("idle_cnt",   txn_cnt,  num);
    step();
    chk("idle_valid2", up_valid, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    run_txn(4,   16'h0010, 32'hFFFF_FFFF, 0, 0);
    run_txn(3,   16'h1234, 32'hFFFF_FFF1, 0, 0);
    run_txn(4,   16'hFFFE, 32'hFFFF_FFFF, 0, 0);
    run_txn(0,   16'hAAAA, 32'hFFFF_FFFF, 0, 0);
    run_txn(6,   16'h0100, 32'hFFFF_FFFF, 3, 0);
    run_txn(5,   16'h2000, 32'hFFFF_FFFF, 0, 2);
    run_txn(4,   16'h3000, 32'hFFFF_FFFF, 0, 0);
    for (int i = 0; i < 8; i++)
      run_txn($urandom_range(1, 40), DW'($urandom), $urandom, $urandom_range(0, 5), 0);
    run_txn(100, 16'h4000, 32'hFFFF_FFFF, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
